// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile controller.
//   tile_state_e : controller phase encoding (LOAD -> MAC -> DRAIN -> OUT)
//   cnt_width()  : counter width for a 0..n-1 count, never below 1 bit
//   *_CNT_W      : counter widths for the default 4x4, DEPTH=8 tile
package systolic_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } tile_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_ROWS        = 4;
  localparam int unsigned DEF_COLS        = 4;
  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEPTH_CNT_W     = cnt_width(DEF_DEPTH);
  localparam int unsigned DRAIN_CNT_W     = cnt_width((DEF_ROWS > DEF_COLS) ? DEF_ROWS : DEF_COLS);
  localparam int unsigned ROW_CNT_W       = cnt_width(DEF_ROWS);

endpackage

// File: rtl/systolic_skew_chain.sv
// Diagonal skew chain: tap 0 follows the input combinationally, tap i is
// the input delayed by i cycles. Synchronous active-high clear.
// Ports:
//   clk, rst : clock, synchronous reset (active-high)
//   i_in     : 1-bit enable entering the chain
//   o_taps   : N-bit skewed copies of i_in
module systolic_skew_chain #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in,
  output logic [N-1:0] o_taps
);

  generate
    if (N == 1) begin : g_single
      assign o_taps = i_in;
    end else begin : g_chain
      logic [N-1:1] r_skew;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_skew <= '0;
        end else begin
          r_skew[1] <= i_in;
          for (int unsigned i = 2; i < N; i++) begin
            r_skew[i] <= r_skew[i-1];
          end
        end
      end

      assign o_taps = {r_skew, i_in};
    end
  endgenerate

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Controller for a ROWS x COLS systolic MAC tile.
// Fills per-row X and per-column W FIFOs, streams DEPTH operands per channel
// with a one-cycle diagonal skew, drains the wavefront, then hands results
// out one row per valid/ready beat and re-arms for the next tile.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   x_recv_val/x_recv_rdy         : X operand broadcast handshake
//   w_recv_val/w_recv_rdy         : W operand broadcast handshake
//   x_fifo_full/empty/wen/ren     : per-row X FIFO status and strobes
//   w_fifo_full/empty/wen/ren     : per-column W FIFO status and strobes
//   mac_en                        : PE accumulate enable (MAC and DRAIN)
//   acc_clr                       : one-cycle PE accumulator clear
//   out_val/out_rdy/out_row       : result row handshake and row index
//   err                           : sticky read-while-empty flag
// Build option SYSTOLIC_TILE_CTRL_PERF_EN adds perf_cycles[31:0]: cycles spent
// in MAC+DRAIN+OUT by the last completed tile.
module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          x_recv_val,
  output logic                          x_recv_rdy,
  input  logic                          w_recv_val,
  output logic                          w_recv_rdy,
  input  logic [ROWS-1:0]               x_fifo_full,
  input  logic [ROWS-1:0]               x_fifo_empty,
  output logic [ROWS-1:0]               x_fifo_wen,
  output logic [ROWS-1:0]               x_fifo_ren,
  input  logic [COLS-1:0]               w_fifo_full,
  input  logic [COLS-1:0]               w_fifo_empty,
  output logic [COLS-1:0]               w_fifo_wen,
  output logic [COLS-1:0]               w_fifo_ren,
  output logic                          mac_en,
  output logic                          acc_clr,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [cnt_width(ROWS)-1:0]    out_row,
  output logic                          err
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int unsigned MAX_RC    = (ROWS > COLS) ? ROWS : COLS;
  // Skew tail of MAX_RC-1 cycles plus one PE pipeline cycle; collapses to 1
  // when the array is a single PE.
  localparam int unsigned DRAIN_LEN = MAX_RC;
  localparam int unsigned DEPTH_W   = cnt_width(DEPTH);
  localparam int unsigned DRAIN_W   = cnt_width(DRAIN_LEN);
  localparam int unsigned ROW_W     = cnt_width(ROWS);

  localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(DEPTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);

  tile_state_e          r_state;
  tile_state_e          w_next;
  logic [DEPTH_W-1:0]   r_mac_cnt;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [ROW_W-1:0]     r_row;
  logic                 r_acc_clr;
  logic                 r_err;

  logic                 w_x_rdy;
  logic                 w_w_rdy;
  logic                 w_mac_active;
  logic                 w_mac_last;
  logic                 w_drain_last;
  logic                 w_tile_done;
  logic                 w_underflow;

  assign w_x_rdy      = ~&x_fifo_full;
  assign w_w_rdy      = ~&w_fifo_full;
  assign w_mac_active = (r_state == MAC);
  assign w_mac_last   = (r_mac_cnt == DEPTH_LAST);
  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);
  assign w_tile_done  = (r_state == OUT) && out_rdy && (r_row == ROW_LAST);
  assign w_underflow  = (|(x_fifo_ren & x_fifo_empty)) | (|(w_fifo_ren & w_fifo_empty));

  // Row/column 0 read directly from the MAC state; later channels see the
  // same enable delayed by their index, forming the diagonal wavefront.
  systolic_skew_chain #(.N(ROWS)) u_x_skew (
    .clk    (clk),
    .rst    (rst),
    .i_in   (w_mac_active),
    .o_taps (x_fifo_ren)
  );

  systolic_skew_chain #(.N(COLS)) u_w_skew (
    .clk    (clk),
    .rst    (rst),
    .i_in   (w_mac_active),
    .o_taps (w_fifo_ren)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_mac_cnt   <= '0;
      r_drain_cnt <= '0;
      r_row       <= '0;
      r_acc_clr   <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_acc_clr <= w_tile_done;
      r_err     <= r_err | w_underflow;

      if (r_state == MAC && !w_mac_last) begin
        r_mac_cnt <= r_mac_cnt + 1'b1;
      end else begin
        r_mac_cnt <= '0;
      end

      if (r_state == DRAIN && !w_drain_last) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end

      if (r_state == OUT && out_rdy) begin
        r_row <= w_tile_done ? '0 : r_row + 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    x_recv_rdy = 1'b0;
    w_recv_rdy = 1'b0;
    x_fifo_wen = '0;
    w_fifo_wen = '0;
    mac_en     = 1'b0;
    out_val    = 1'b0;
    case (r_state)
      LOAD: begin
        x_recv_rdy = w_x_rdy;
        w_recv_rdy = w_w_rdy;
        x_fifo_wen = {ROWS{x_recv_val & w_x_rdy}} & ~x_fifo_full;
        w_fifo_wen = {COLS{w_recv_val & w_w_rdy}} & ~w_fifo_full;
        if ((&x_fifo_full) && (&w_fifo_full)) begin
          w_next = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (w_mac_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        mac_en = 1'b1;
        if (w_drain_last) begin
          w_next = OUT;
        end
      end
      OUT: begin
        out_val = 1'b1;
        if (w_tile_done) begin
          w_next = LOAD;
        end
      end
      default: w_next = LOAD;
    endcase
  end

  assign out_row = r_row;
  assign acc_clr = r_acc_clr;
  // The sticky register lags by a cycle; OR in the live condition so err is
  // visible in the same cycle as the offending read.
  assign err     = r_err | w_underflow;

`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf;

  // The running count excludes the current cycle, so the final OUT cycle is
  // added when latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt <= '0;
      r_perf     <= '0;
    end else if (r_state != LOAD) begin
      if (w_tile_done) begin
        r_perf     <= r_perf_cnt + 32'd1;
        r_perf_cnt <= '0;
      end else begin
        r_perf_cnt <= r_perf_cnt + 32'd1;
      end
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
module tb_systolic_tile_ctrl;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int D  = 8;
  localparam int R2 = 2;
  localparam int C2 = 6;
  localparam int D2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT 1: 4x4, DEPTH 8 ----------------
  logic         x_recv_val, x_recv_rdy, w_recv_val, w_recv_rdy;
  logic [R-1:0] x_fifo_full, x_fifo_empty, x_fifo_wen, x_fifo_ren;
  logic [C-1:0] w_fifo_full, w_fifo_empty, w_fifo_wen, w_fifo_ren;
  logic         mac_en, acc_clr, out_val, out_rdy, err;
  logic [1:0]   out_row;
  logic [31:0]  perf_cycles;
  logic [R-1:0] x_force;

  systolic_tile_ctrl #(.ROWS(R), .COLS(C), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst),
    .x_recv_val(x_recv_val), .x_recv_rdy(x_recv_rdy),
    .w_recv_val(w_recv_val), .w_recv_rdy(w_recv_rdy),
    .x_fifo_full(x_fifo_full), .x_fifo_empty(x_fifo_empty),
    .x_fifo_wen(x_fifo_wen), .x_fifo_ren(x_fifo_ren),
    .w_fifo_full(w_fifo_full), .w_fifo_empty(w_fifo_empty),
    .w_fifo_wen(w_fifo_wen), .w_fifo_ren(w_fifo_ren),
    .mac_en(mac_en), .acc_clr(acc_clr),
    .out_val(out_val), .out_rdy(out_rdy), .out_row(out_row),
    .err(err)
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // ---------------- DUT 2: 2x6, DEPTH 3 ----------------
  logic          x2_val, x2_rdy, w2_val, w2_rdy;
  logic [R2-1:0] x2_full, x2_empty, x2_wen, x2_ren;
  logic [C2-1:0] w2_full, w2_empty, w2_wen, w2_ren;
  logic          mac_en2, acc_clr2, out_val2, out_rdy2, err2;
  logic [0:0]    out_row2;
  logic [31:0]   perf_cycles2;

  systolic_tile_ctrl #(.ROWS(R2), .COLS(C2), .DEPTH(D2)) u_dut2 (
    .clk(clk), .rst(rst),
    .x_recv_val(x2_val), .x_recv_rdy(x2_rdy),
    .w_recv_val(w2_val), .w_recv_rdy(w2_rdy),
    .x_fifo_full(x2_full), .x_fifo_empty(x2_empty),
    .x_fifo_wen(x2_wen), .x_fifo_ren(x2_ren),
    .w_fifo_full(w2_full), .w_fifo_empty(w2_empty),
    .w_fifo_wen(w2_wen), .w_fifo_ren(w2_ren),
    .mac_en(mac_en2), .acc_clr(acc_clr2),
    .out_val(out_val2), .out_rdy(out_rdy2), .out_row(out_row2),
    .err(err2)
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles2)
`endif
  );

  // ---------------- FIFO occupancy models ----------------
  int xc[R]   = '{default: 0};
  int wc[C]   = '{default: 0};
  int xc2[R2] = '{default: 0};
  int wc2[C2] = '{default: 0};

  always_comb begin
    for (int i = 0; i < R; i++) begin
      x_fifo_full[i]  = (xc[i] == D);
      x_fifo_empty[i] = (xc[i] == 0) || x_force[i];
    end
    for (int i = 0; i < C; i++) begin
      w_fifo_full[i]  = (wc[i] == D);
      w_fifo_empty[i] = (wc[i] == 0);
    end
    for (int i = 0; i < R2; i++) begin
      x2_full[i]  = (xc2[i] == D2);
      x2_empty[i] = (xc2[i] == 0);
    end
    for (int i = 0; i < C2; i++) begin
      w2_full[i]  = (wc2[i] == D2);
      w2_empty[i] = (wc2[i] == 0);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < R; i++)
      xc[i] <= xc[i] + (x_fifo_wen[i] ? 1 : 0) - ((x_fifo_ren[i] && xc[i] > 0) ? 1 : 0);
    for (int i = 0; i < C; i++)
      wc[i] <= wc[i] + (w_fifo_wen[i] ? 1 : 0) - ((w_fifo_ren[i] && wc[i] > 0) ? 1 : 0);
    for (int i = 0; i < R2; i++)
      xc2[i] <= xc2[i] + (x2_wen[i] ? 1 : 0) - ((x2_ren[i] && xc2[i] > 0) ? 1 : 0);
    for (int i = 0; i < C2; i++)
      wc2[i] <= wc2[i] + (w2_wen[i] ? 1 : 0) - ((w2_ren[i] && wc2[i] > 0) ? 1 : 0);
  end

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // MAC/DRAIN window of a 4x4 DEPTH=8 tile, indexed by cycles since entering MAC.
  typedef struct {
    logic       recv_val;
    logic       rdy;
    logic [3:0] exp_xren;
    logic [3:0] exp_wren;
    logic       exp_mac;
  } vec_t;
  vec_t tbl[12];

  task automatic run_table(input int kmax, input bit probe_err);
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      x_recv_val = tbl[k].recv_val;
      w_recv_val = tbl[k].recv_val;
      out_rdy    = tbl[k].rdy;
      x_force    = probe_err ? 4'b0100 : 4'b0000;
      #1;
      check("x_ren", 32'(x_fifo_ren), 32'(tbl[k].exp_xren));
      check("w_ren", 32'(w_fifo_ren), 32'(tbl[k].exp_wren));
      check("mac_en", 32'(mac_en), 32'(tbl[k].exp_mac));
      check("no_wen_busy", 32'({x_fifo_wen, w_fifo_wen}), 32'd0);
      if (probe_err && k <= 2) check("err_rise", 32'(err), (k == 2) ? 32'd1 : 32'd0);
    end
    x_force = '0;
  endtask

  task automatic fill(input logic [3:0] last_wen);
    for (int b = 0; b < D; b++) begin
      @(negedge clk);
      x_recv_val = 1'b1;
      w_recv_val = 1'b1;
      out_rdy    = 1'b0;
      #1;
      check("fill_rdy", 32'({x_recv_rdy, w_recv_rdy}), 32'd3);
      check("fill_xwen", 32'(x_fifo_wen), (b == D - 1) ? 32'(last_wen) : 32'hF);
      check("fill_wwen", 32'(w_fifo_wen), (b == D - 1) ? 32'(last_wen) : 32'hF);
    end
    @(negedge clk);
    #1;
    check("full_rdy_low", 32'({x_recv_rdy, w_recv_rdy}), 32'd0);
    check("full_no_wen", 32'({x_fifo_wen, w_fifo_wen}), 32'd0);
    check("full_no_mac", 32'(mac_en), 32'd0);
  endtask

  task automatic drain_out();
    for (int j = 0; j < R; j++) begin
      @(negedge clk);
      x_recv_val = 1'b0;
      w_recv_val = 1'b0;
      out_rdy    = 1'b1;
      #1;
      check("drain_val", 32'(out_val), 32'd1);
      check("drain_row", 32'(out_row), 32'(j));
    end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    check("drain_load_val", 32'(out_val), 32'd0);
    check("drain_acc_clr", 32'(acc_clr), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'h1, 4'h1, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 4'h3, 4'h3, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 4'h7, 4'h7, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 4'hF, 4'hF, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'hF, 4'hF, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 4'hE, 4'hE, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'hC, 4'hC, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 4'h8, 4'h8, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1};

    rst = 1'b1;
    x_recv_val = 1'b0; w_recv_val = 1'b0; out_rdy = 1'b0; x_force = '0;
    x2_val = 1'b0; w2_val = 1'b0; out_rdy2 = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_recv_rdy", 32'({x_recv_rdy, w_recv_rdy}), 32'd3);
    check("rst_wen", 32'({x_fifo_wen, w_fifo_wen}), 32'd0);
    check("rst_ren", 32'({x_fifo_ren, w_fifo_ren}), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_out_row", 32'(out_row), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_acc_clr", 32'(acc_clr), 32'd1);
    check("rst_acc_clr2", 32'(acc_clr2), 32'd1);
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    check("rst_perf", perf_cycles, 32'd0);
`endif
    @(negedge clk);
    #1;
    check("acc_clr_one_cycle", 32'(acc_clr), 32'd0);

    // Asymmetric 2x6 DEPTH=3 tile
    begin
      int w0_first, w5_first, w5_n, x1_n, mac_n;
      w0_first = -1; w5_first = -1; w5_n = 0; x1_n = 0; mac_n = 0;
      for (int b = 0; b < D2; b++) begin
        @(negedge clk);
        x2_val = 1'b1; w2_val = 1'b1;
        #1;
        check("a_fill_wen", 32'({x2_wen, w2_wen}), 32'hFF);
      end
      @(negedge clk);
      #1;
      check("a_full_rdy", 32'({x2_rdy, w2_rdy}), 32'd0);
      for (int k = 0; k <= 10; k++) begin
        @(negedge clk);
        x2_val = 1'b0; w2_val = 1'b0; out_rdy2 = 1'b1;
        #1;
        if (w2_ren[0] && w0_first < 0) w0_first = k;
        if (w2_ren[5]) begin
          w5_n++;
          if (w5_first < 0) w5_first = k;
        end
        if (x2_ren[1]) x1_n++;
        if (mac_en2) mac_n++;
        if (k == 9)  check("a_row0", 32'(out_row2), 32'd0);
        if (k == 10) check("a_row1", 32'(out_row2), 32'd1);
      end
      check("a_w0_first", 32'(w0_first), 32'd0);
      check("a_w5_first", 32'(w5_first), 32'd5);
      check("a_w5_len", 32'(w5_n), 32'd3);
      check("a_x1_len", 32'(x1_n), 32'd3);
      check("a_mac_len", 32'(mac_n), 32'd9);
      @(negedge clk);
      out_rdy2 = 1'b0;
      #1;
      check("a_load_val", 32'(out_val2), 32'd0);
      check("a_acc_clr", 32'(acc_clr2), 32'd1);
      check("a_err", 32'(err2), 32'd0);
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
      check("a_perf", perf_cycles2, 32'd11);
`endif
    end

    // Tile 1: fill, skewed MAC window, output backpressure
    fill(4'hF);
    run_table(11, 1'b0);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      x_recv_val = 1'b0; w_recv_val = 1'b0; out_rdy = 1'b0;
      #1;
      check("bp_val", 32'(out_val), 32'd1);
      check("bp_row_hold", 32'(out_row), 32'd0);
      if (h == 0) check("bp_mac_off", 32'(mac_en), 32'd0);
    end
    for (int j = 0; j < R; j++) begin
      @(negedge clk);
      out_rdy = 1'b1;
      #1;
      check("bp_beat_row", 32'(out_row), 32'(j));
      check("bp_beat_val", 32'(out_val), 32'd1);
      if (j < R - 1) begin
        @(negedge clk);
        out_rdy = 1'b0;
        #1;
        check("bp_gap_row", 32'(out_row), 32'(j + 1));
      end
    end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    check("bp_load_val", 32'(out_val), 32'd0);
    check("bp_acc_clr", 32'(acc_clr), 32'd1);
    check("bp_load_rdy", 32'({x_recv_rdy, w_recv_rdy}), 32'd3);
    check("bp_err", 32'(err), 32'd0);
    @(negedge clk);
    #1;
    check("bp_acc_clr_off", 32'(acc_clr), 32'd0);

    // Tile 2: underflow on row 2, err sticky, full-rate output
    fill(4'hF);
    run_table(11, 1'b1);
    drain_out();
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    check("perf_tile", perf_cycles, 32'd16);
`endif
    repeat (2) @(negedge clk);
    #1;
    check("err_sticky", 32'(err), 32'd1);

    // Tile 3: reset during DRAIN, then a complete tile
    fill(4'hF);
    run_table(9, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    x_recv_val = 1'b0; w_recv_val = 1'b0;
    #1;
    check("mrst_ren", 32'({x_fifo_ren, w_fifo_ren}), 32'd0);
    check("mrst_mac_en", 32'(mac_en), 32'd0);
    check("mrst_out_val", 32'(out_val), 32'd0);
    check("mrst_load_rdy", 32'({x_recv_rdy, w_recv_rdy}), 32'd3);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_acc_clr", 32'(acc_clr), 32'd1);
    // Row/column 3 still holds one operand, so it fills one beat early.
    fill(4'b0111);
    run_table(11, 1'b0);
    drain_out();
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    check("perf_after_rst", perf_cycles, 32'd16);
`endif
    check("final_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
